// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT/IFFT blocks: FSM state type,
// conjugated (inverse) twiddle table in Q8.8, and 3-bit bit reversal.
package fft_pkg;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_e;

  // W^k conjugated: cos(2*pi*k/8) + j*sin(2*pi*k/8), k = 0..3, Q8.8
  localparam logic signed [15:0] TW_RE [4] = '{16'sh0100, 16'sh00b5, 16'sh0000, 16'shff4b};
  localparam logic signed [15:0] TW_IM [4] = '{16'sh0000, 16'sh00b5, 16'sh0100, 16'sh00b5};

  function automatic logic [2:0] bit_reverse3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/bfly_2p.sv
// Radix-2 DIT butterfly: top = A + W*B, bot = A - W*B.
// Complex product kept at full 2*DATA_WIDTH, then truncated by >>> FRAC_BITS;
// sums wrap at DATA_WIDTH.
module bfly_2p #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic signed [DATA_WIDTH-1:0] a_re,
  input  logic signed [DATA_WIDTH-1:0] a_im,
  input  logic signed [DATA_WIDTH-1:0] b_re,
  input  logic signed [DATA_WIDTH-1:0] b_im,
  input  logic signed [DATA_WIDTH-1:0] w_re,
  input  logic signed [DATA_WIDTH-1:0] w_im,
  output logic signed [DATA_WIDTH-1:0] top_re,
  output logic signed [DATA_WIDTH-1:0] top_im,
  output logic signed [DATA_WIDTH-1:0] bot_re,
  output logic signed [DATA_WIDTH-1:0] bot_im
);

  logic signed [2*DATA_WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [DATA_WIDTH-1:0]   m_re, m_im;

  // complex multiply W*B, then add/subtract against A
  always_comb begin
    p_rr   = b_re * w_re;
    p_ii   = b_im * w_im;
    p_ri   = b_re * w_im;
    p_ir   = b_im * w_re;
    m_re   = DATA_WIDTH'((p_rr - p_ii) >>> FRAC_BITS);
    m_im   = DATA_WIDTH'((p_ri + p_ir) >>> FRAC_BITS);
    top_re = a_re + m_re;
    top_im = a_im + m_im;
    bot_re = a_re - m_re;
    bot_im = a_im - m_im;
  end

endmodule

// File: rtl/ifft_8p.sv
// 8-point radix-2 DIT inverse FFT, one shared butterfly, 12 compute cycles.
// Frame in/out over valid/ready; output is held in the work registers.
// Optional IFFT_STAGE_SCALE_EN: each butterfly output >>>1 at writeback
// (overall 1/8, true IFFT). Without it the result is 8 * IFFT(X).
module ifft_8p
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int N          = 8
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0]   X_real,
  input  logic [N-1:0][DATA_WIDTH-1:0]   X_imag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N-1:0][DATA_WIDTH-1:0]   x_real,
  output logic [N-1:0][DATA_WIDTH-1:0]   x_imag
);

  if (N != 8) begin : g_bad_n
    $error("ifft_8p supports N = 8 only");
  end

  state_e                         state_q, state_d;
  logic [1:0]                     stage_q, stage_d;
  logic [1:0]                     bfly_q, bfly_d;
  logic [N-1:0][DATA_WIDTH-1:0]   work_re_q, work_re_d;
  logic [N-1:0][DATA_WIDTH-1:0]   work_im_q, work_im_d;

  logic [2:0] span, low, hi, top_idx, bot_idx;
  logic [1:0] tw_k;
  logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic signed [DATA_WIDTH-1:0] t_re, t_im, u_re, u_im;
  logic signed [DATA_WIDTH-1:0] t_re_w, t_im_w, u_re_w, u_im_w;

  // butterfly addressing and operand mux for the current (stage, bfly)
  always_comb begin
    span    = 3'd1 << stage_q;
    low     = {1'b0, bfly_q} & (span - 3'd1);
    hi      = {1'b0, bfly_q} >> stage_q;
    top_idx = (hi << (stage_q + 2'd1)) + low;
    bot_idx = top_idx + span;
    tw_k    = 2'(low << (2'd2 - stage_q));
    a_re    = work_re_q[top_idx];
    a_im    = work_im_q[top_idx];
    b_re    = work_re_q[bot_idx];
    b_im    = work_im_q[bot_idx];
    w_re    = DATA_WIDTH'(TW_RE[tw_k]);
    w_im    = DATA_WIDTH'(TW_IM[tw_k]);
  end

  bfly_2p #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_bfly (
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im),
    .top_re(t_re), .top_im(t_im), .bot_re(u_re), .bot_im(u_im)
  );

  // optional per-stage halving before writeback
  always_comb begin
`ifdef IFFT_STAGE_SCALE_EN
    t_re_w = t_re >>> 1;
    t_im_w = t_im >>> 1;
    u_re_w = u_re >>> 1;
    u_im_w = u_im >>> 1;
`else
    t_re_w = t_re;
    t_im_w = t_im;
    u_re_w = u_re;
    u_im_w = u_im;
`endif
  end

  // FSM: load bit-reversed frame, run 3x4 butterflies in place, hold result
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    bfly_d    = bfly_q;
    work_re_d = work_re_q;
    work_im_d = work_im_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < N; k++) begin
            work_re_d[k] = X_real[bit_reverse3(3'(k))];
            work_im_d[k] = X_imag[bit_reverse3(3'(k))];
          end
          state_d = CALC;
          stage_d = 2'd0;
          bfly_d  = 2'd0;
        end
      end
      CALC: begin
        work_re_d[top_idx] = t_re_w;
        work_im_d[top_idx] = t_im_w;
        work_re_d[bot_idx] = u_re_w;
        work_im_d[bot_idx] = u_im_w;
        bfly_d = bfly_q + 2'd1;
        if (bfly_q == 2'd3) begin
          if (stage_q == 2'd2) state_d = OUT;
          else                 stage_d = stage_q + 2'd1;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and work registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      bfly_q    <= '0;
      work_re_q <= '0;
      work_im_q <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      bfly_q    <= bfly_d;
      work_re_q <= work_re_d;
      work_im_q <= work_im_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign x_real    = work_re_q;
  assign x_imag    = work_im_q;

endmodule

// File: tb/tb_ifft_8p.sv
// Bench for ifft_8p: directed + random frames against a behavioural
// IFFT model (integer radix-2 flow from the arithmetic rules) and a
// floating-point forward FFT for round-trip checks.
module tb_ifft_8p;

`ifdef IFFT_STAGE_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0][15:0] X_real, X_imag, x_real, x_imag;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifft_8p dut (
    .clk(clk), .arst_n(arst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .X_real(X_real), .X_imag(X_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_real(x_real), .x_imag(x_imag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = (obs > exp) ? obs - exp : exp - obs;
    n_chk++;
    assert (d <= tol) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int w16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  // Reference: bit-reverse load, then 3 radix-2 stages with the specified
  // Q8.8 truncating multiply, 16-bit wrapping sums and optional halving.
  function automatic void ifft_model(input int ir[8], input int ii[8],
                                     output int orr[8], output int oi[8]);
    int wr[4] = '{256, 181, 0, -181};
    int wi[4] = '{0, 181, 256, 181};
    int ar[8], ai[8];
    int span, t, u, k, pr, pi, tr, ti, br, bi;
    for (int n = 0; n < 8; n++) begin
      int r;
      r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      ar[n] = w16(ir[r]);
      ai[n] = w16(ii[r]);
    end
    for (int s = 0; s < 3; s++) begin
      span = 1 << s;
      for (int b = 0; b < 4; b++) begin
        t  = (b >> s) * 2 * span + (b % span);
        u  = t + span;
        k  = (b % span) << (2 - s);
        pr = w16((ar[u] * wr[k] - ai[u] * wi[k]) >>> 8);
        pi = w16((ar[u] * wi[k] + ai[u] * wr[k]) >>> 8);
        tr = w16(ar[t] + pr); ti = w16(ai[t] + pi);
        br = w16(ar[t] - pr); bi = w16(ai[t] - pi);
        if (SCALE) begin
          tr = tr >>> 1; ti = ti >>> 1; br = br >>> 1; bi = bi >>> 1;
        end
        ar[t] = tr; ai[t] = ti; ar[u] = br; ai[u] = bi;
      end
    end
    orr = ar;
    oi  = ai;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a frame and wait (bounded) until it is accepted.
  task automatic send(input int r[8], input int i[8]);
    int w = 0;
    for (int k = 0; k < 8; k++) begin
      X_real[k] = 16'(r[k]);
      X_imag[k] = 16'(i[k]);
    end
    in_valid = 1'b1;
    while (!in_ready && w < 40) begin tick(); w++; end
    chk("accept_timeout", 32'(w < 40), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges (accept edge = 1) until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin tick(); lat++; end
    chk("latency", 32'(lat), 32'd13);
  endtask

  task automatic grab(output int orr[8], output int oi[8]);
    for (int k = 0; k < 8; k++) begin
      orr[k] = int'($signed(x_real[k]));
      oi[k]  = int'($signed(x_imag[k]));
    end
  endtask

  // Full frame with out_ready already high: send, wait, capture, consume.
  task automatic run_frame(input int r[8], input int i[8], output int orr[8], output int oi[8]);
    int lat;
    send(r, i);
    wait_out(lat);
    grab(orr, oi);
    tick();
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  task automatic cmp_model(input string tag, input int r[8], input int i[8],
                           input int orr[8], input int oi[8]);
    int er[8], ei[8];
    ifft_model(r, i, er, ei);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_re%0d", tag, k), 32'(orr[k]), 32'(er[k]));
      chk($sformatf("%s_im%0d", tag, k), 32'(oi[k]), 32'(ei[k]));
    end
  endtask

  initial begin
    int r[8], i[8], orr[8], oi[8], lat, amp, tol, g;
    logic [7:0][15:0] snap_r, snap_i;
    real ang, sr, si;
    int xr0[8], xi0[8];

    arst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    X_real = '0; X_imag = '0;
    tick(); tick();

    // reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_x_real", 32'(x_real == '0), 32'd1);
    chk("rst_x_imag", 32'(x_imag == '0), 32'd1);
    arst_n = 1'b1;
    tick();

    // impulse: flat spectrum in time domain
    r = '{256, 0, 0, 0, 0, 0, 0, 0}; i = '{default: 0};
    run_frame(r, i, orr, oi);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("imp_re%0d", k), 32'(orr[k]), SCALE ? 32'h20 : 32'h100);
      chk($sformatf("imp_im%0d", k), 32'(oi[k]), 32'd0);
    end

    // single bin 1: rotating phasor
    r = '{0, 'h800, 0, 0, 0, 0, 0, 0}; i = '{default: 0};
    run_frame(r, i, orr, oi);
    amp = SCALE ? 'h100 : 'h800;
    tol = SCALE ? 2 : 16;
    for (int k = 0; k < 8; k++) begin
      ang = 2.0 * 3.14159265358979 * k / 8.0;
      chk_tol($sformatf("bin1_re%0d", k), orr[k], int'(amp * $cos(ang)), tol);
      chk_tol($sformatf("bin1_im%0d", k), oi[k], int'(amp * $sin(ang)), tol);
    end
    cmp_model("bin1", r, i, orr, oi);

    // backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      r[k] = int'($urandom_range(0, 'h7ff)) - 'h400;
      i[k] = int'($urandom_range(0, 'h7ff)) - 'h400;
    end
    send(r, i);
    wait_out(lat);
    snap_r = x_real; snap_i = x_imag;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", 32'(x_real == snap_r && x_imag == snap_i), 32'd1);
    end
    in_valid = 1'b0;
    grab(orr, oi);
    cmp_model("bp", r, i, orr, oi);
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_consumed_once", 32'(out_valid), 32'd0);

    // reset during computation discards the frame
    for (int k = 0; k < 8; k++) begin
      r[k] = int'($urandom_range(1, 'h3ff));
      i[k] = int'($urandom_range(1, 'h3ff));
    end
    send(r, i);
    for (int c = 0; c < 5; c++) tick();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_x_real", 32'(x_real == '0), 32'd1);
    chk("mid_rst_x_imag", 32'(x_imag == '0), 32'd1);
    run_frame(r, i, orr, oi);
    cmp_model("after_rst", r, i, orr, oi);

    // random full-range frames against the model
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 8; k++) begin
        r[k] = w16(int'($urandom));
        i[k] = w16(int'($urandom));
      end
      run_frame(r, i, orr, oi);
      cmp_model($sformatf("rand%0d", f), r, i, orr, oi);
    end

    // round trip: float forward FFT, then DUT
    amp = SCALE ? 'h3ff : 'h7f;
    g   = SCALE ? 1 : 8;
    tol = SCALE ? 4 : 32;
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 8; n++) begin
        xr0[n] = int'($urandom_range(0, 2 * amp)) - amp;
        xi0[n] = int'($urandom_range(0, 2 * amp)) - amp;
      end
      for (int k = 0; k < 8; k++) begin
        sr = 0.0; si = 0.0;
        for (int n = 0; n < 8; n++) begin
          ang = 2.0 * 3.14159265358979 * k * n / 8.0;
          sr += xr0[n] * $cos(ang) + xi0[n] * $sin(ang);
          si += xi0[n] * $cos(ang) - xr0[n] * $sin(ang);
        end
        r[k] = int'(sr);
        i[k] = int'(si);
      end
      run_frame(r, i, orr, oi);
      for (int n = 0; n < 8; n++) begin
        chk_tol($sformatf("rt%0d_re%0d", f, n), orr[n], g * xr0[n], tol);
        chk_tol($sformatf("rt%0d_im%0d", f, n), oi[n], g * xi0[n], tol);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
